// File: rtl/ring_osc_sequencer.sv
// Measurement sequencer for a ring-oscillator timer: gates the oscillator for a
// programmable window, freezes and captures its count, accumulates N samples.
module ring_osc_sequencer #(
  parameter int WINDOW_W = 8,
  parameter int ACC_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic [3:0]          num_samples,
  input  logic [7:0]          timer_out,
  output logic                timer_slow_clk,
  output logic                timer_enable,
  output logic                timer_signal,
  output logic                busy,
  output logic [ACC_W-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                overflow,
  output logic                sample_err
);

  // The shared down-counter must also hold the fixed ARM/SETTLE durations.
  localparam int CNT_W = (WINDOW_W > 2) ? WINDOW_W : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WINDOW,
    S_STOP,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [4:0]         nsamp_q, nsamp_d;
  logic [4:0]         samp_cnt_q, samp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               expected_q, expected_d;
  logic [7:0]         sync1_q, sync2_q;
  logic               slow_q, slow_d;
  logic               enable_q, enable_d;
  logic               signal_q, signal_d;
  logic               busy_q, busy_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;
  logic               sample_err_q, sample_err_d;
  logic [ACC_W:0]     acc_sum;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    nsamp_d      = nsamp_q;
    samp_cnt_d   = samp_cnt_q;
    acc_d        = acc_q;
    expected_d   = expected_q;
    signal_d     = signal_q;
    result_d     = result_q;
    valid_d      = valid_q;
    overflow_d   = overflow_q;
    sample_err_d = sample_err_q;
    acc_sum      = {1'b0, acc_q} + (ACC_W + 1)'(sync2_q[5:0]);

    if (valid_q && result_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !valid_q) begin
          state_d      = S_ARM;
          cnt_d        = CNT_W'(1);
          // win holds L-1 so the WINDOW countdown ends on zero.
          win_d        = (window_len == '0) ? '0 : CNT_W'(window_len) - CNT_W'(1);
          nsamp_d      = (num_samples == 4'd0) ? 5'd16 : {1'b0, num_samples};
          samp_cnt_d   = 5'd0;
          acc_d        = '0;
          overflow_d   = 1'b0;
          sample_err_d = 1'b0;
        end
      end

      S_ARM: begin
        expected_d = signal_q;
        if (cnt_q == '0) begin
          state_d = S_WINDOW;
          cnt_d   = win_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WINDOW: begin
        if (cnt_q == '0) begin
          state_d  = S_STOP;
          signal_d = ~signal_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_STOP: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_W'(2);
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        if (acc_sum[ACC_W]) begin
          acc_d      = '1;
          overflow_d = 1'b1;
        end else begin
          acc_d = acc_sum[ACC_W-1:0];
        end
        if (sync2_q[6]) begin
          overflow_d = 1'b1;
        end
        if (sync2_q[7] != expected_q) begin
          sample_err_d = 1'b1;
        end
        samp_cnt_d = samp_cnt_q + 5'd1;
        if (samp_cnt_q + 5'd1 == nsamp_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ARM;
          cnt_d   = CNT_W'(1);
        end
      end

      S_DONE: begin
        result_d = acc_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timer controls are registered from the next state. slow_clk drops on
    // entry to CAPTURE; the synchroniser still holds the frozen count then.
    slow_d   = (state_d == S_WINDOW) || (state_d == S_STOP) || (state_d == S_SETTLE);
    enable_d = (state_d != S_IDLE) && (state_d != S_DONE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      win_q        <= '0;
      nsamp_q      <= 5'd0;
      samp_cnt_q   <= 5'd0;
      acc_q        <= '0;
      expected_q   <= 1'b0;
      sync1_q      <= 8'd0;
      sync2_q      <= 8'd0;
      slow_q       <= 1'b0;
      enable_q     <= 1'b0;
      signal_q     <= 1'b0;
      busy_q       <= 1'b0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      sample_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      nsamp_q      <= nsamp_d;
      samp_cnt_q   <= samp_cnt_d;
      acc_q        <= acc_d;
      expected_q   <= expected_d;
      sync1_q      <= timer_out;
      sync2_q      <= sync1_q;
      slow_q       <= slow_d;
      enable_q     <= enable_d;
      signal_q     <= signal_d;
      busy_q       <= busy_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      sample_err_q <= sample_err_d;
    end
  end

  assign timer_slow_clk = slow_q;
  assign timer_enable   = enable_q;
  assign timer_signal   = signal_q;
  assign busy           = busy_q;
  assign result         = result_q;
  assign result_valid   = valid_q;
  assign overflow       = overflow_q;
  assign sample_err     = sample_err_q;

endmodule

// File: tb/tb_ring_osc_sequencer.sv
// Scoreboard bench for ring_osc_sequencer with a behavioural ring-oscillator timer model.
module tb_ring_osc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  window_len;
  logic [3:0]  num_samples;
  logic [7:0]  timer_out;
  logic        timer_slow_clk;
  logic        timer_enable;
  logic        timer_signal;
  logic        busy;
  logic [10:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overflow;
  logic        sample_err;

  ring_osc_sequencer #(.WINDOW_W(8), .ACC_W(11)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .window_len     (window_len),
    .num_samples    (num_samples),
    .timer_out      (timer_out),
    .timer_slow_clk (timer_slow_clk),
    .timer_enable   (timer_enable),
    .timer_signal   (timer_signal),
    .busy           (busy),
    .result         (result),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .overflow       (overflow),
    .sample_err     (sample_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: count cleared and latch transparent while slow_clk is low;
  // count advances by 'rate' per clk while signal matches the latched level.
  int         rate      = 6;
  bit         fixed63   = 1'b0;
  int         strobe_at = -1;
  int         err_at    = -1;
  logic [5:0] m_cnt     = 6'd0;
  logic       m_saved   = 1'b0;
  logic       m_prev_slow = 1'b0;
  int         m_idx     = 0;

  always @(posedge clk) begin
    m_prev_slow <= timer_slow_clk;
    if (!timer_enable) m_idx <= 0;
    else if (timer_slow_clk && !m_prev_slow) m_idx <= m_idx + 1;
    if (!timer_enable || !timer_slow_clk) begin
      m_cnt   <= 6'd0;
      m_saved <= timer_signal;
    end else if (timer_signal == m_saved) begin
      m_cnt <= m_cnt + 6'(rate);
    end
  end

  assign timer_out = {m_saved ^ (m_idx == err_at), (m_idx == strobe_at), fixed63 ? 6'd63 : m_cnt};

  typedef struct {
    int res;
    int ovf;
    int err;
    int lat;
    int slow;
    int tog;
  } exp_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: owns all comparisons; runs on every falling edge.
  initial begin
    logic  prev_busy, prev_valid, prev_sig;
    int    run_cyc, slow_hi, tog;
    exp_t  e;
    dchk_t d;
    prev_busy = 1'b0; prev_valid = 1'b0; prev_sig = 1'b0;
    run_cyc = 0; slow_hi = 0; tog = 0;
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        run_cyc = 0; slow_hi = 0; tog = 0;
      end else begin
        run_cyc++;
      end
      if (timer_slow_clk) slow_hi++;
      if (timer_signal != prev_sig) tog++;
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0d, want no result", result);
        end else begin
          e = exp_q.pop_front();
          $display("result=%0d overflow=%0d sample_err=%0d latency=%0d slow_high=%0d toggles=%0d",
                   result, overflow, sample_err, run_cyc, slow_hi, tog);
          cmp("result", int'(result), e.res);
          cmp("overflow", int'(overflow), e.ovf);
          cmp("sample_err", int'(sample_err), e.err);
          cmp("latency", run_cyc, e.lat);
          cmp("slow_clk_high", slow_hi, e.slow);
          cmp("signal_toggles", tog, e.tog);
        end
      end
      while (dq.size() > 0) begin
        d = dq.pop_front();
        cmp(d.name, d.act, d.exp);
      end
      prev_busy  = busy;
      prev_valid = result_valid;
      prev_sig   = timer_signal;
    end
  end

  task automatic dchk(input string name, input int act, input int exp);
    dchk_t d;
    d.name = name; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic push_exp(input int l, input int n, input int res, input int ovf, input int err);
    exp_t e;
    int   le, ne;
    le = (l == 0) ? 1 : l;
    ne = (n == 0) ? 16 : n;
    e.res = res; e.ovf = ovf; e.err = err;
    e.lat = ne * (le + 7) + 1;
    e.slow = ne * (le + 4);
    e.tog = ne;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int l, input int n);
    @(negedge clk); #1;
    window_len = 8'(l); num_samples = 4'(n); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    if (!seen) dchk("timeout_valid", int'(result_valid), 1);
  endtask

  task automatic do_run(input int l, input int n, input int res, input int ovf, input int err);
    push_exp(l, n, res, ovf, err);
    pulse_start(l, n);
    wait_valid();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int  rises;
    bit  ps;
    rst_n = 1'b0; start = 1'b0; window_len = 8'd0; num_samples = 4'd0; result_ready = 1'b1;

    @(negedge clk);
    dchk("rst_slow_clk", int'(timer_slow_clk), 0);
    dchk("rst_enable", int'(timer_enable), 0);
    dchk("rst_signal", int'(timer_signal), 0);
    dchk("rst_busy", int'(busy), 0);
    dchk("rst_result", int'(result), 0);
    dchk("rst_valid", int'(result_valid), 0);
    dchk("rst_overflow", int'(overflow), 0);
    dchk("rst_sample_err", int'(sample_err), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Basic window: 4 cycles at 6 edges each.
    do_run(4, 1, 24, 0, 0);
    // window_len 0 behaves as 1.
    do_run(0, 1, 6, 0, 0);
    // 16 samples of fixed 63.
    fixed63 = 1'b1;
    do_run(1, 0, 1008, 0, 0);
    // Strobe on the 3rd capture.
    strobe_at = 3;
    do_run(1, 0, 1008, 1, 0);
    strobe_at = -1;
    // 40 captures over three runs never wrap an 11-bit accumulator.
    do_run(1, 0, 1008, 0, 0);
    do_run(1, 0, 1008, 0, 0);
    do_run(1, 8, 504, 0, 0);
    fixed63 = 1'b0;

    // Saved-signal mismatch on sample 2 of 3, starting from reset.
    apply_reset();
    dchk("signal_after_reset", int'(timer_signal), 0);
    err_at = 2;
    do_run(4, 3, 72, 0, 1);
    err_at = -1;
    dchk("signal_after_3", int'(timer_signal), 1);

    // Back-pressure: result held, start ignored while valid.
    result_ready = 1'b0;
    push_exp(2, 1, 12, 0, 0);
    pulse_start(2, 1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dchk("hold_valid", int'(result_valid), 1);
      dchk("hold_result", int'(result), 12);
      if (i >= 4) dchk("hold_not_busy", int'(busy), 0);
      if (i == 2) begin #1; window_len = 8'd5; num_samples = 4'd1; start = 1'b1; end
      if (i == 3) begin #1; start = 1'b0; end
    end
    #1;
    result_ready = 1'b1;
    @(negedge clk);
    dchk("valid_cleared", int'(result_valid), 0);
    do_run(3, 1, 18, 0, 0);

    // Asynchronous reset in the window of the 2nd sample.
    pulse_start(4, 2);
    rises = 0;
    ps = timer_slow_clk;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (timer_slow_clk && !ps) rises++;
      ps = timer_slow_clk;
    end
    dchk("second_window_reached", rises, 2);
    #2;
    rst_n = 1'b0;
    #1;
    dchk("async_slow_clk", int'(timer_slow_clk), 0);
    dchk("async_enable", int'(timer_enable), 0);
    dchk("async_signal", int'(timer_signal), 0);
    dchk("async_busy", int'(busy), 0);
    dchk("async_valid", int'(result_valid), 0);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    do_run(4, 2, 48, 0, 0);

    dchk("pending_results", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
